dht_sensor_ctrl: RTL and testbench
==================================

Name: dht_sensor_ctrl

Overview:
Parametrised single-wire controller for DHT11/DHT22 temperature/humidity sensors. Issues the host start pulse and decodes the 40-bit frame by measuring each bit's high-pulse width with a 1 us timebase. Verifies the checksum, flags timeouts, and presents full 16-bit humidity/temperature words.
It sits between the sampling scheduler (which drives start) and the display/alarm logic (which consumes data_rdy and the values).

Parameters:
CLK_HZ, 50_000_000, system clock frequency; must be an integer multiple of 1_000_000.
POWERUP_MS, 1000, sensor settle time after reset before the first start is accepted.
START11_US, 18000, host low time in DHT11 mode.
START22_US, 1000, host low time in DHT22 mode.
BIT1_THRESH_US, 48, a high pulse of at least this many us decodes as 1, otherwise 0.
TIMEOUT_US, 200, maximum duration of any single wait/measure phase.
MIN_GAP_MS, 1000, minimum time from the end of one transaction to the next accepted start.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
start  in  1  level request; a rising edge (2-FF synced) requests a transaction
mode  in  1  0=DHT11, 1=DHT22; sampled at accepted start
data  inout  1  sensor bus; driven only when link=1 (drive 0), else high-Z
busy  out  1  high from accepted start until return to IDLE
data_rdy  out  1  one-cycle pulse: new valid values
err_timeout  out  1  last transaction aborted on a timeout
err_checksum  out  1  last frame had a checksum mismatch
humidity  out  16  frame bytes 0..1 {int,dec} (DHT22: x10 %RH)
temperature  out  16  frame bytes 2..3 (DHT22: bit15 = sign, magnitude x10 C)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=POWERUP, link=0 (bus released that edge), all counters 0, busy=0, data_rdy=0, err_*=0, humidity=0, temperature=0.
- Reset mid-transaction: the bus is released at that edge and no partial data is published.
- us_tick: prescaler pulses once every CLK_HZ/1e6 cycles. All timing counters are in us, with widths derived via $clog2.
- Bus input passes through a 2-FF synchroniser. Edges are detected on the synced value, so edge latency is 2-3 clk.
- FSM:
  - POWERUP: wait POWERUP_MS, then IDLE. A start edge arriving here is dropped, not queued.
  - IDLE: wait for a start edge with gap counter >= MIN_GAP_MS. A start edge arriving earlier is dropped.
  - On an accepted start: latch mode, busy=1, clear err_*, link=1 (drive 0), go to START_LOW.
  - START_LOW: hold low START11_US or START22_US, then link=0, go to WAIT_RESP.
  - WAIT_RESP: wait for the synced bus low (sensor response) -> RESP_LOW.
  - RESP_LOW: wait for a rising edge -> RESP_HIGH.
  - RESP_HIGH: wait for a falling edge -> BIT_LOW, bit index = 0.
  - BIT_LOW: wait for a rising edge -> BIT_HIGH, width counter cleared.
  - BIT_HIGH: count us while the bus is high. On the falling edge, shift in (width >= BIT1_THRESH_US), MSB first. Bit index 39 -> CHECK, else -> BIT_LOW.
  - CHECK (1 cycle): sum = (byte0+byte1+byte2+byte3) mod 256.
    - If sum == byte4: update humidity/temperature, pulse data_rdy.
    - Else: err_checksum=1, outputs hold their previous values.
    - Either way -> IDLE.
- Timeout: each of WAIT_RESP..BIT_HIGH has its own phase counter reset on entry. Reaching TIMEOUT_US gives err_timeout=1, link=0, -> IDLE, with outputs and data_rdy unchanged.
- On every return to IDLE: busy=0 and the gap counter restarts from 0. The gap counter saturates.
- err_* are sticky until the next accepted start.
- A start edge while busy=1 is ignored.
- data is never driven high. The pull-up is external.

Test Plan:
1. Sim params: CLK_HZ=1e6, POWERUP_MS=1, MIN_GAP_MS=1. Sensor model DHT11 sends 0x37,0x00,0x19,0x00,0x50 -> bus held low 18000 us, then humidity=0x3700, temperature=0x1900, data_rdy one pulse, err=00, busy falls.
2. DHT22 mode, frame 0x02,0x8C,0x80,0x65,0x73 -> low 1000 us, humidity=0x028C, temperature=0x8065 (-10.1 C), data_rdy pulse.
3. DHT11 frame with checksum byte 0x51 -> err_checksum=1, no data_rdy, humidity/temperature keep their previous values.
4. Sensor gives no response after release -> err_timeout=1 exactly TIMEOUT_US after entering WAIT_RESP, link=0, busy=0. Also: sensor stalls high mid-bit 17 -> err_timeout=1.
5. Start edge during POWERUP, during busy, and 500 us after a finish (MIN_GAP_MS=1) -> all ignored, data never driven. A start edge at 1000 us is accepted.
6. rst_n=0 during BIT_HIGH -> bus high-Z at that edge, outputs zero, POWERUP restarts, no data_rdy.
Boundary: bit high widths of 47 us and 48 us decode as 0 and 1.

Source files
------------

// File: rtl/dht_sensor_ctrl.sv
// rtl/dht_sensor_ctrl.sv - DHT11/DHT22 single-wire controller
// Issues the host start pulse, decodes 40 bits by high-pulse width, verifies the checksum.
module dht_sensor_ctrl #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int POWERUP_MS     = 1000,
  parameter int START11_US     = 18000,
  parameter int START22_US     = 1000,
  parameter int BIT1_THRESH_US = 48,
  parameter int TIMEOUT_US     = 200,
  parameter int MIN_GAP_MS     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  inout  wire         data,
  output logic        busy,
  output logic        data_rdy,
  output logic        err_timeout,
  output logic        err_checksum,
  output logic [15:0] humidity,
  output logic [15:0] temperature
);
  localparam int DIV        = CLK_HZ / 1_000_000;
  localparam int PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POWERUP_US = POWERUP_MS * 1000;
  localparam int GAP_US     = MIN_GAP_MS * 1000;
  localparam int M1         = (POWERUP_US > GAP_US) ? POWERUP_US : GAP_US;
  localparam int M2         = (START11_US > START22_US) ? START11_US : START22_US;
  localparam int M3         = (M2 > TIMEOUT_US) ? M2 : TIMEOUT_US;
  localparam int TMAX       = (M1 > M3) ? M1 : M3;
  localparam int TW         = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_POWERUP = TW'(POWERUP_US);
  localparam logic [TW-1:0] T_GAP     = TW'(GAP_US);
  localparam logic [TW-1:0] T_START11 = TW'(START11_US);
  localparam logic [TW-1:0] T_START22 = TW'(START22_US);
  localparam logic [TW-1:0] T_THRESH  = TW'(BIT1_THRESH_US);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_US);
  localparam logic [TW-1:0] T_SAT     = '1;

  typedef enum logic [3:0] {
    S_POWERUP, S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre_cnt;
  logic          us_tick;
  logic [1:0]    start_sync, bus_sync;
  logic          start_d, bus_d;
  logic          start_rise, bus_rise, bus_fall;
  logic [TW-1:0] t_us, t_nxt, start_t;
  logic [5:0]    bit_idx;
  logic [39:0]   shreg;
  logic [7:0]    sum;
  logic          csum_ok, mode_q;
  logic          accept, shift_en, bit_val, timeout_ev, link;

  assign us_tick = (pre_cnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)       pre_cnt <= '0;
    else if (us_tick) pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + PW'(1);
  end

  // Synchronisers idle high so the released bus never looks like an edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_sync <= 2'b00;
      start_d    <= 1'b0;
      bus_sync   <= 2'b11;
      bus_d      <= 1'b1;
    end else begin
      start_sync <= {start_sync[0], start};
      start_d    <= start_sync[1];
      bus_sync   <= {bus_sync[0], data};
      bus_d      <= bus_sync[1];
    end
  end

  assign start_rise = start_sync[1] & ~start_d;
  assign bus_rise   = bus_sync[1] & ~bus_d;
  assign bus_fall   = ~bus_sync[1] & bus_d;

  // t_nxt includes the tick landing this cycle, so a pulse of N us measures exactly N.
  assign t_nxt   = (t_us == T_SAT) ? t_us : t_us + TW'(us_tick);
  assign start_t = mode_q ? T_START22 : T_START11;
  assign bit_val = (t_nxt >= T_THRESH);

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    timeout_ev = 1'b0;
    case (state)
      S_POWERUP:   if (t_nxt >= T_POWERUP) state_n = S_IDLE;
      S_IDLE: begin
        if (start_rise && (t_us >= T_GAP)) begin
          accept  = 1'b1;
          state_n = S_START_LOW;
        end
      end
      S_START_LOW: if (t_nxt >= start_t) state_n = S_WAIT_RESP;
      // The bus still reads our own low for a few cycles after release, so wait for a fresh fall.
      S_WAIT_RESP: if (bus_fall) state_n = S_RESP_LOW;
                   else if (t_nxt >= T_TIMEOUT) timeout_ev = 1'b1;
      S_RESP_LOW:  if (bus_rise) state_n = S_RESP_HIGH;
                   else if (t_nxt >= T_TIMEOUT) timeout_ev = 1'b1;
      S_RESP_HIGH: if (bus_fall) state_n = S_BIT_LOW;
                   else if (t_nxt >= T_TIMEOUT) timeout_ev = 1'b1;
      S_BIT_LOW:   if (bus_rise) state_n = S_BIT_HIGH;
                   else if (t_nxt >= T_TIMEOUT) timeout_ev = 1'b1;
      S_BIT_HIGH: begin
        if (bus_fall) begin
          shift_en = 1'b1;
          state_n  = (bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
        end else if (t_nxt >= T_TIMEOUT) begin
          timeout_ev = 1'b1;
        end
      end
      S_CHECK:     state_n = S_IDLE;
      default:     state_n = S_POWERUP;
    endcase
    if (timeout_ev) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_POWERUP;
      t_us    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state <= state_n;
      t_us  <= (state_n != state) ? '0 : t_nxt;
      if (state == S_RESP_HIGH && bus_fall) bit_idx <= '0;
      else if (shift_en)                    bit_idx <= bit_idx + 6'd1;
      if (shift_en) shreg  <= {shreg[38:0], bit_val};
      if (accept)   mode_q <= mode;
    end
  end

  assign sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign csum_ok = (sum == shreg[7:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_rdy     <= 1'b0;
      err_timeout  <= 1'b0;
      err_checksum <= 1'b0;
      humidity     <= '0;
      temperature  <= '0;
    end else begin
      data_rdy <= 1'b0;
      if (accept) begin
        err_timeout  <= 1'b0;
        err_checksum <= 1'b0;
      end
      if (timeout_ev) err_timeout <= 1'b1;
      if (state == S_CHECK) begin
        if (csum_ok) begin
          humidity    <= shreg[39:24];
          temperature <= shreg[23:8];
          data_rdy    <= 1'b1;
        end else begin
          err_checksum <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != S_POWERUP) && (state != S_IDLE);
  assign link = (state == S_START_LOW);
  assign data = link ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht_sensor_ctrl.sv
// tb/tb_dht_sensor_ctrl.sv - scoreboard bench for dht_sensor_ctrl
// Sensor model drives the bus open-drain; a monitor checks each transaction end against a queue.
module tb_dht_sensor_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        sens_low = 1'b0;
  wire         data;
  logic        busy, data_rdy, err_timeout, err_checksum;
  logic [15:0] humidity, temperature;

  assign data = sens_low ? 1'b0 : 1'bz;
  pullup (data);

  dht_sensor_ctrl #(
    .CLK_HZ(1_000_000), .POWERUP_MS(1), .START11_US(18000), .START22_US(1000),
    .BIT1_THRESH_US(48), .TIMEOUT_US(200), .MIN_GAP_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .data(data),
    .busy(busy), .data_rdy(data_rdy), .err_timeout(err_timeout),
    .err_checksum(err_checksum), .humidity(humidity), .temperature(temperature)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    logic [15:0] hum;
    logic [15:0] temp;
    bit          et;
    bit          ec;
  } exp_t;

  localparam int K_NORMAL = 0, K_NORESP = 1, K_STALL = 2, K_RESET = 3, K_TOGGLE = 4;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mdl_hum = 16'h0;
  logic [15:0] mdl_temp = 16'h0;
  bit          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic hold(input bit low, input int n);
    sens_low = low;
    repeat (n) @(negedge clk);
  endtask

  // Reference: a frame is a list of five bytes; publish only when the first four sum to the fifth.
  task automatic push_exp(input logic [39:0] fr, input int kind);
    exp_t e;
    logic [7:0] b[5];
    int s;
    for (int k = 0; k < 5; k++) b[k] = fr[39-8*k -: 8];
    s = (int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256;
    e.et = 1'b0;
    e.ec = 1'b0;
    e.rdy = 1'b0;
    if (kind == K_NORESP || kind == K_STALL) begin
      e.et = 1'b1;
    end else if (s == int'(b[4])) begin
      mdl_hum  = {b[0], b[1]};
      mdl_temp = {b[2], b[3]};
      e.rdy = 1'b1;
    end else begin
      e.ec = 1'b1;
    end
    e.hum  = mdl_hum;
    e.temp = mdl_temp;
    exp_q.push_back(e);
  endtask

  function automatic logic [39:0] rand_frame(input bit good);
    logic [7:0] b0, b1, b2, b3, s;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    b3 = 8'($urandom);
    s  = b0 + b1 + b2 + b3;
    if (!good) s = s + 8'($urandom_range(1, 255));
    return {b0, b1, b2, b3, s};
  endfunction

  task automatic quiet_window(input string name, input int n);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0 || data !== 1'b1) ok = 1'b0;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_txn(input bit md, input logic [39:0] fr, input int kind,
                         input int at_bit, input bit tight);
    int cnt;
    int w;
    if (kind != K_RESET) push_exp(fr, kind);
    @(negedge clk);
    mode  = md;
    start = 1'b1;
    cnt = 0;
    while (data !== 1'b0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("start_accepted", 32'(data === 1'b0), 32'd1);
    cnt = 0;
    while (data === 1'b0 && cnt < 20000) begin
      cnt++;
      @(negedge clk);
    end
    chk("host_low_us", 32'(cnt), md ? 32'd1000 : 32'd18000);
    start = 1'b0;
    if (kind == K_NORESP) begin
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
        cnt++;
        @(negedge clk);
      end
      chk("noresp_timeout_us", 32'(cnt), 32'd200);
      return;
    end
    hold(1'b0, 25);
    hold(1'b1, 80);
    hold(1'b0, 80);
    for (int i = 0; i < 40; i++) begin
      if (kind == K_TOGGLE && i == 5) start = 1'b1;
      if (kind == K_TOGGLE && i == 10) start = 1'b0;
      hold(1'b1, 30);
      if (kind == K_STALL && i == at_bit) begin
        sens_low = 1'b0;
        break;
      end
      if (kind == K_RESET && i == at_bit) begin
        sens_low = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_bus_released", 32'(data), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data_rdy", 32'(data_rdy), 32'd0);
        chk("rst_humidity", 32'(humidity), 32'd0);
        chk("rst_temperature", 32'(temperature), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_checksum}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mdl_hum  = 16'h0;
        mdl_temp = 16'h0;
        return;
      end
      if (tight) w = fr[39-i] ? 48 : 47;
      else       w = fr[39-i] ? int'($urandom_range(48, 55)) : int'($urandom_range(20, 26));
      hold(1'b0, w);
    end
    if (kind != K_STALL) hold(1'b1, 30);
    sens_low = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 600) begin
      cnt++;
      @(negedge clk);
    end
    chk("txn_end_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: a falling busy closes a transaction; data_rdy anywhere else is a stray pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_txn_end", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_rdy", 32'(data_rdy), 32'(mon_e.rdy));
          chk("humidity", 32'(humidity), 32'(mon_e.hum));
          chk("temperature", 32'(temperature), 32'(mon_e.temp));
          chk("err_timeout", 32'(err_timeout), 32'(mon_e.et));
          chk("err_checksum", 32'(err_checksum), 32'(mon_e.ec));
        end
      end else if (data_rdy) begin
        chk("stray_data_rdy", 32'(data_rdy), 32'd0);
      end
      prev_busy = busy;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_data_rdy", 32'(data_rdy), 32'd0);
    chk("reset_errs", 32'({err_timeout, err_checksum}), 32'd0);
    chk("reset_humidity", 32'(humidity), 32'd0);
    chk("reset_temperature", 32'(temperature), 32'd0);
    chk("reset_bus_released", 32'(data), 32'd1);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    pulse_start();
    quiet_window("powerup_start_ignored", 2200);

    run_txn(1'b0, 40'h3700190050, K_NORMAL, 0, 1'b0);
    repeat (1010) @(negedge clk);

    run_txn(1'b1, 40'h028C806573, K_TOGGLE, 0, 1'b0);
    repeat (500) @(negedge clk);
    pulse_start();
    quiet_window("gap_start_ignored", 400);
    repeat (110) @(negedge clk);

    run_txn(1'b0, 40'h3700190051, K_NORMAL, 0, 1'b0);
    repeat (1010) @(negedge clk);
    run_txn(1'b1, rand_frame(1'b1), K_NORMAL, 0, 1'b1);
    repeat (1010) @(negedge clk);
    run_txn(1'b1, rand_frame($urandom_range(0, 1) == 1), K_NORMAL, 0, 1'b0);
    repeat (1010) @(negedge clk);
    run_txn(1'b1, 40'h0, K_NORESP, 0, 1'b0);
    repeat (1010) @(negedge clk);
    run_txn(1'b1, rand_frame(1'b1), K_STALL, 17, 1'b0);
    repeat (1010) @(negedge clk);
    run_txn(1'b1, rand_frame(1'b1), K_RESET, 20, 1'b0);
    repeat (100) @(negedge clk);
    pulse_start();
    quiet_window("post_reset_powerup_ignored", 2200);
    run_txn(1'b1, rand_frame(1'b1), K_NORMAL, 0, 1'b0);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
